hazard_ctrl: RTL and testbench

- Producer side of the operand-forwarding interface.
- Tracks destination register, write-enable and writeback source of the instructions in EX (stage 2) and MEM (stage 3).
- Drives rf_rd_2r, rf_rd_3r and wb_sel_3r to the forwarding unit.
- Generates stall, flush and bubble controls for load-use hazards, taken branches and multicycle data-memory access, and keeps saturating hazard performance counters.

---
 rtl/hazard_ctrl.sv | 103 ++++++++++
 tb/tb_hazard_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: tracks EX/MEM destinations for forwarding and generates stall/flush/hold controls with saturating hazard counters
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic [4:0]       id_rd,
   input  logic             id_rf_we,
   input  logic             id_wb_sel,
   input  logic             ex_branch_taken,
   input  logic             mem_ready,
   output logic [4:0]       rf_rd_2r,
   output logic [4:0]       rf_rd_3r,
   output logic             wb_sel_3r,
   output logic             stall_if,
   output logic             stall_id,
   output logic             flush_id,
   output logic             hold_ex_mem,
   output logic [CNT_W-1:0] lu_stall_cnt,
   output logic [CNT_W-1:0] mem_stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT} state_t;
   state_t           state_q, state_d;
   logic [4:0]       rd_2_q, rd_2_d, rd_3_q, rd_3_d;
   logic             we_2_q, we_2_d, we_3_q, we_3_d;
   logic             wbs_2_q, wbs_2_d, wbs_3_q, wbs_3_d;
   logic [CNT_W-1:0] lu_cnt_q, lu_cnt_d, mem_cnt_q, mem_cnt_d, fl_cnt_q, fl_cnt_d;
   logic             mem_wait, lu_hit, lu_stall, flush, take_id;

   assign mem_wait = we_3_q && wbs_3_q && !mem_ready;
   assign lu_hit   = id_valid && we_2_q && wbs_2_q && rd_2_q != 5'd0 &&
                     ((id_use_rs1 && id_rs1 == rd_2_q) || (id_use_rs2 && id_rs2 == rd_2_q));
   assign flush    = !mem_wait && ex_branch_taken;
   assign lu_stall = !mem_wait && !ex_branch_taken && lu_hit;
   assign take_id  = id_valid && !flush && !lu_stall;

   assign stall_if      = mem_wait || lu_stall;
   assign stall_id      = mem_wait || lu_stall;
   assign flush_id      = flush;
   assign hold_ex_mem   = mem_wait;
   assign rf_rd_2r      = we_2_q ? rd_2_q : 5'd0;
   assign rf_rd_3r      = we_3_q ? rd_3_q : 5'd0;
   assign wb_sel_3r     = wbs_3_q && rf_rd_3r != 5'd0;
   assign lu_stall_cnt  = lu_cnt_q;
   assign mem_stall_cnt = mem_cnt_q;
   assign flush_cnt     = fl_cnt_q;

   // FSM next state: a memory wait dominates; a load-use bubble only starts from RUN and lasts one cycle
   always_comb begin
      state_d = state_q;
      state_d = mem_wait ? MEM_WAIT : (state_q == RUN && lu_stall) ? LU_BUBBLE : RUN;
   end

   // stage advance: both stages freeze on a memory wait, otherwise stage 2 takes ID or a bubble
   always_comb begin
      rd_3_d  = mem_wait ? rd_3_q  : rd_2_q;
      we_3_d  = mem_wait ? we_3_q  : we_2_q;
      wbs_3_d = mem_wait ? wbs_3_q : wbs_2_q;
      rd_2_d  = mem_wait ? rd_2_q  : take_id ? id_rd : 5'd0;
      we_2_d  = mem_wait ? we_2_q  : take_id && id_rf_we;
      wbs_2_d = mem_wait ? wbs_2_q : take_id && id_wb_sel;
   end

   // saturating hazard counters
   always_comb begin
      lu_cnt_d  = (lu_stall && ~&lu_cnt_q)  ? lu_cnt_q + 1'b1  : lu_cnt_q;
      mem_cnt_d = (mem_wait && ~&mem_cnt_q) ? mem_cnt_q + 1'b1 : mem_cnt_q;
      fl_cnt_d  = (flush && ~&fl_cnt_q)     ? fl_cnt_q + 1'b1  : fl_cnt_q;
   end

   // state, stage and counter registers with asynchronous clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= RUN;
         rd_2_q    <= '0;
         we_2_q    <= 1'b0;
         wbs_2_q   <= 1'b0;
         rd_3_q    <= '0;
         we_3_q    <= 1'b0;
         wbs_3_q   <= 1'b0;
         lu_cnt_q  <= '0;
         mem_cnt_q <= '0;
         fl_cnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         rd_2_q    <= rd_2_d;
         we_2_q    <= we_2_d;
         wbs_2_q   <= wbs_2_d;
         rd_3_q    <= rd_3_d;
         we_3_q    <= we_3_d;
         wbs_3_q   <= wbs_3_d;
         lu_cnt_q  <= lu_cnt_d;
         mem_cnt_q <= mem_cnt_d;
         fl_cnt_q  <= fl_cnt_d;
      end
   end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed test-plan steps plus random traffic checked against a pipeline reference model
module tb_hazard_ctrl;
   localparam int CNT_W = 8;
   localparam int CMAX  = (1 << CNT_W) - 1;
   logic             clk = 1'b0;
   logic             rst;
   logic             id_valid, id_use_rs1, id_use_rs2, id_rf_we, id_wb_sel, ex_branch_taken, mem_ready;
   logic [4:0]       id_rs1, id_rs2, id_rd;
   logic [4:0]       rf_rd_2r, rf_rd_3r;
   logic             wb_sel_3r, stall_if, stall_id, flush_id, hold_ex_mem;
   logic [CNT_W-1:0] lu_stall_cnt, mem_stall_cnt, flush_cnt;
   int               checks = 0, errors = 0;
   typedef struct {bit we; bit ld; int rd;} ins_t;
   ins_t             s2, s3, n2, n3;
   int               c_lu, c_mem, c_fl, n_lu, n_mem, n_fl;

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .id_rd(id_rd), .id_rf_we(id_rf_we),
      .id_wb_sel(id_wb_sel), .ex_branch_taken(ex_branch_taken), .mem_ready(mem_ready),
      .rf_rd_2r(rf_rd_2r), .rf_rd_3r(rf_rd_3r), .wb_sel_3r(wb_sel_3r), .stall_if(stall_if),
      .stall_id(stall_id), .flush_id(flush_id), .hold_ex_mem(hold_ex_mem),
      .lu_stall_cnt(lu_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      s2.we = 0; s2.ld = 0; s2.rd = 0;
      s3 = s2;
      c_lu = 0; c_mem = 0; c_fl = 0;
   endtask

   task automatic set_id(input logic v, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                         input logic u2, input logic [4:0] rd, input logic we, input logic ld);
      id_valid = v; id_rs1 = r1; id_use_rs1 = u1; id_rs2 = r2; id_use_rs2 = u2;
      id_rd = rd; id_rf_we = we; id_wb_sel = ld;
   endtask

   task automatic settle();
      bit mw, hit, lus, fl;
      int r2, r3;
      #1;
      mw  = s3.we && s3.ld && !mem_ready;
      hit = id_valid && s2.we && s2.ld && s2.rd != 0 &&
            ((id_use_rs1 && int'(id_rs1) == s2.rd) || (id_use_rs2 && int'(id_rs2) == s2.rd));
      fl  = ex_branch_taken && !mw;
      lus = hit && !mw && !ex_branch_taken;
      r2  = s2.we ? s2.rd : 0;
      r3  = s3.we ? s3.rd : 0;
      chk("rf_rd_2r", rf_rd_2r, r2);
      chk("rf_rd_3r", rf_rd_3r, r3);
      chk("wb_sel_3r", wb_sel_3r, r3 != 0 && s3.ld);
      chk("stall_if", stall_if, mw || lus);
      chk("stall_id", stall_id, mw || lus);
      chk("flush_id", flush_id, fl);
      chk("hold_ex_mem", hold_ex_mem, mw);
      chk("lu_stall_cnt", lu_stall_cnt, c_lu);
      chk("mem_stall_cnt", mem_stall_cnt, c_mem);
      chk("flush_cnt", flush_cnt, c_fl);
      n3 = mw ? s3 : s2;
      if (mw) n2 = s2;
      else if (id_valid && !fl && !lus) begin
         n2.we = id_rf_we; n2.ld = id_wb_sel; n2.rd = id_rd;
      end else begin
         n2.we = 0; n2.ld = 0; n2.rd = 0;
      end
      n_lu  = c_lu  + ((lus && c_lu  < CMAX) ? 1 : 0);
      n_mem = c_mem + ((mw  && c_mem < CMAX) ? 1 : 0);
      n_fl  = c_fl  + ((fl  && c_fl  < CMAX) ? 1 : 0);
   endtask

   task automatic tick();
      @(posedge clk);
      s2 = n2; s3 = n3; c_lu = n_lu; c_mem = n_mem; c_fl = n_fl;
      @(negedge clk);
   endtask

   task automatic step();
      settle();
      tick();
   endtask

   initial begin
      rst = 1'b1; ex_branch_taken = 1'b0; mem_ready = 1'b1;
      set_id(0, 0, 0, 0, 0, 0, 0, 0);
      model_reset();
      #2;
      settle();
      chk("reset_hold", hold_ex_mem, 0);
      @(negedge clk);
      rst = 1'b0;
      // load-use: load x5 then add x6,x5,x1
      set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
      set_id(1, 5, 1, 1, 1, 6, 1, 0); settle();
      chk("lu_c1_rd2", rf_rd_2r, 5);
      chk("lu_c1_stall_if", stall_if, 1);
      chk("lu_c1_stall_id", stall_id, 1);
      tick(); settle();
      chk("lu_c2_rd2", rf_rd_2r, 0);
      chk("lu_c2_rd3", rf_rd_3r, 5);
      chk("lu_c2_wb3", wb_sel_3r, 1);
      chk("lu_c2_stall", stall_if, 0);
      chk("lu_c2_cnt", lu_stall_cnt, 1);
      tick();
      // ALU producer x7 then consumer
      set_id(1, 0, 0, 0, 0, 7, 1, 0); step();
      set_id(1, 7, 1, 7, 1, 8, 1, 0); settle();
      chk("alu_stall", stall_if, 0);
      chk("alu_rd2", rf_rd_2r, 7);
      tick();
      set_id(0, 0, 0, 0, 0, 0, 0, 0); settle();
      chk("alu_rd3", rf_rd_3r, 7);
      chk("alu_wb3", wb_sel_3r, 0);
      tick();
      // load to x0 then reader of x0
      set_id(1, 0, 0, 0, 0, 0, 1, 1); step();
      set_id(1, 0, 1, 0, 1, 9, 1, 0); settle();
      chk("x0_stall", stall_if, 0);
      chk("x0_rd2", rf_rd_2r, 0);
      tick();
      // taken branch concurrent with load-use
      set_id(1, 0, 0, 0, 0, 5, 1, 1); step();
      set_id(1, 5, 1, 0, 0, 6, 1, 0); ex_branch_taken = 1'b1; settle();
      chk("br_flush", flush_id, 1);
      chk("br_stall_if", stall_if, 0);
      tick();
      ex_branch_taken = 1'b0; set_id(0, 0, 0, 0, 0, 0, 0, 0); settle();
      chk("br_rd2", rf_rd_2r, 0);
      chk("br_flush_cnt", flush_cnt, 1);
      chk("br_lu_cnt", lu_stall_cnt, 1);
      tick();
      // load x9 waits three cycles in MEM, branch during the wait is ignored
      set_id(1, 0, 0, 0, 0, 9, 1, 1); step();
      set_id(1, 0, 0, 0, 0, 4, 1, 0); step();
      set_id(1, 0, 0, 0, 0, 10, 1, 0); mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ex_branch_taken = (i == 1); settle();
         chk("mw_hold", hold_ex_mem, 1);
         chk("mw_rd3", rf_rd_3r, 9);
         chk("mw_flush", flush_id, 0);
         tick();
      end
      ex_branch_taken = 1'b0; mem_ready = 1'b1; settle();
      chk("mw_cnt", mem_stall_cnt, 3);
      chk("mw_release", hold_ex_mem, 0);
      tick(); settle();
      chk("mw_adv_rd3", rf_rd_3r, 4);
      chk("mw_adv_rd2", rf_rd_2r, 10);
      tick();
      // asynchronous reset in the middle of a memory wait
      set_id(1, 0, 0, 0, 0, 9, 1, 1); step();
      set_id(0, 0, 0, 0, 0, 0, 0, 0); step();
      set_id(1, 0, 0, 0, 0, 3, 1, 0); mem_ready = 1'b0; step();
      #2;
      rst = 1'b1;
      model_reset();
      settle();
      chk("rst_mid_hold", hold_ex_mem, 0);
      chk("rst_mid_rd3", rf_rd_3r, 0);
      chk("rst_mid_mcnt", mem_stall_cnt, 0);
      @(negedge clk);
      rst = 1'b0; mem_ready = 1'b1;
      // counter saturation
      set_id(1, 5, 1, 0, 0, 5, 1, 1);
      for (int k = 0; k < 2000 && c_lu < CMAX - 1; k++) step();
      settle();
      chk("sat_pre", lu_stall_cnt, CMAX - 1);
      tick();
      repeat (6) step();
      settle();
      chk("sat_max", lu_stall_cnt, CMAX);
      tick();
      // random traffic
      repeat (3000) begin
         set_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1,
                5'($urandom_range(0, 3)), $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
                $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4);
         ex_branch_taken = $urandom_range(0, 9) == 0;
         mem_ready = $urandom_range(0, 9) < 7;
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
